powlib_swfifo: RTL and testbench
================================

Name: powlib_swfifo

Overview:
- Parametrised single-clock FIFO with valid/ready handshakes on both sides. It is the successor to the plain flip-flop, pipe and single-port RAM primitives.
- Adds arbitrary depth (not limited to powers of two), pointer wrap, an occupancy count, an almost-full flag and a synchronous flush.
- Sits between producer and consumer stages inside one clock domain, as the standard buffering element for bus and stream paths.

Parameters:
- W, 16, data width in bits.
- D, 8, depth in words; minimum 2; any integer value.
- AFT, D-1, almost-full threshold; afull asserts when cnt >= AFT; legal range 1..D.
- WIDX, powlib_clogb2(D), pointer width (derived).
- WCNT, powlib_clogb2(D+1), count width (derived).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous flush; empties the FIFO.
- wrdata  input  W  write data.
- wrvld  input  1  write valid.
- wrrdy  output  1  write ready (not full).
- rddata  output  W  read data; first-word-fall-through.
- rdvld  output  1  read valid (not empty).
- rdrdy  input  1  read ready.
- cnt  output  WCNT  current occupancy, 0..D.
- afull  output  1  almost full.

Behaviour:
- Reset: rst==0 asynchronously clears wrptr, rdptr and cnt to 0. During reset: wrrdy=0, rdvld=0, afull=0, cnt=0. rddata is don't-care.
- After reset: wrrdy=1 in the first cycle after rst rises. Memory contents are not reset.
- Write handshake: a write is accepted on the clk edge where wrvld&&wrrdy. wrdata is stored at mem[wrptr], then wrptr advances.
- Read handshake: a read is accepted on the clk edge where rdvld&&rdrdy, then rdptr advances.
- wrvld may be held with data stable while wrrdy==0. No data is lost or duplicated.
- rddata = mem[rdptr], combinational from storage. It is valid whenever rdvld==1 and is held stable until the read is accepted.
- Latency: a write into an empty FIFO gives rdvld=1 on the next cycle. There is no same-cycle write-to-read bypass.
- Status flags:
  - wrrdy = rst && (cnt != D)
  - rdvld = (cnt != 0)
  - afull = (cnt >= AFT)
  - All three decode from the registered cnt, with no combinational path from wrvld or rdrdy.
- Pointer wrap: each pointer increments modulo D. At value D-1 it goes to 0, which is explicit and correct for non-power-of-two D.
- Count update per edge:
  - write only: cnt+1
  - read only: cnt-1
  - both or neither: cnt unchanged
- Full, cnt==D: wrrdy=0. A simultaneous read is accepted, so cnt becomes D-1 and wrrdy=1 the next cycle. A write offered in that same cycle is not accepted.
- Empty, cnt==0: rdvld=0, so rdrdy is ignored. A write is accepted, giving cnt=1.
- clr==1 on an edge: wrptr, rdptr and cnt are set to 0. This has priority over any write or read in that cycle; those handshakes are discarded even if wrvld/rdrdy were high.
- Reset mid-operation: all contents are lost immediately and the FIFO is empty on release.
- Storage: a W×D register array with no read latency. It may infer distributed RAM.

Optional Feature:
- Macro: POWLIB_SWFIFO_HWM_EN.
- When defined:
  - Adds output port hwm, WCNT bits: the high-water mark, i.e. the maximum cnt reached since the last reset or clr.
  - hwm resets to 0 and is cleared to 0 by clr.
  - Each edge, hwm takes the next-cycle cnt if that is larger, so hwm==cnt in the same cycle cnt peaks.
- When undefined: the port and register are absent; all other behaviour is identical.

Test Plan (W=8, D=5, AFT=4):
- Release reset, write 0x11 once -> next cycle rdvld=1, rddata=0x11, cnt=1. After rdrdy for one cycle: rdvld=0, cnt=0.
- Write 0x01..0x05 back-to-back with rdrdy=0 -> afull rises after the 4th write (cnt=4). wrrdy=0 and cnt=5 after the 5th. A 6th write held pending is not accepted.
- Full FIFO, assert wrvld+rdrdy together -> 0x01 is read and the write is not accepted; cnt=4, wrrdy=1. The next cycle's write is accepted and cnt returns to 5.
- Continuous write+read for 12 cycles with data 0x20..0x2B -> read order matches exactly across pointer wrap at index 4→0; cnt stays constant.
- cnt=3, assert clr together with wrvld=1 and rdrdy=1 -> next cycle cnt=0, rdvld=0, wrrdy=1, nothing written. With POWLIB_SWFIFO_HWM_EN defined, hwm=0.
- cnt=3, drop rst asynchronously mid-cycle -> wrrdy, rdvld, afull and cnt go to 0 without a clk edge. After release, the first write reads back correctly.

Source files
------------

// File: rtl/powlib_swfifo.sv
// powlib_swfifo: single-clock FIFO with valid/ready handshakes on both sides.
// Any depth D >= 2 (power of two not required), first-word-fall-through read
// data, occupancy count, almost-full flag and a synchronous flush.
//
// Optional feature: define POWLIB_SWFIFO_HWM_EN to add the hwm output, the
// maximum occupancy reached since the last reset or clr.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   clr     synchronous flush, overrides any handshake in the same cycle
//   wrdata  write data            wrvld  write valid     wrrdy  write ready
//   rddata  read data (mem[rdptr]) rdvld  read valid      rdrdy  read ready
//   cnt     occupancy 0..D
//   afull   cnt >= AFT
//   hwm     high-water mark (POWLIB_SWFIFO_HWM_EN only)
module powlib_swfifo #(
  parameter int unsigned W    = 16,
  parameter int unsigned D    = 8,
  parameter int unsigned AFT  = D - 1,
  parameter int unsigned WIDX = $clog2(D),
  parameter int unsigned WCNT = $clog2(D + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [W-1:0]    wrdata,
  input  logic            wrvld,
  output logic            wrrdy,
  output logic [W-1:0]    rddata,
  output logic            rdvld,
  input  logic            rdrdy,
  output logic [WCNT-1:0] cnt,
  output logic            afull
`ifdef POWLIB_SWFIFO_HWM_EN
  ,
  output logic [WCNT-1:0] hwm
`endif
);

  logic [W-1:0]    r_mem [D];
  logic [WIDX-1:0] r_wrptr;
  logic [WIDX-1:0] r_rdptr;
  logic [WCNT-1:0] r_cnt;
  logic [WIDX-1:0] w_wrptr_d;
  logic [WIDX-1:0] w_rdptr_d;
  logic [WCNT-1:0] w_cnt_d;
  logic            w_not_full;
  logic            w_not_empty;
  logic            w_wr_en;
  logic            w_rd_en;

  // Flags decode only from the registered count, never from wrvld/rdrdy.
  assign w_not_full  = (r_cnt != WCNT'(D));
  assign w_not_empty = (r_cnt != '0);

  assign wrrdy  = rst && w_not_full;
  assign rdvld  = w_not_empty;
  assign afull  = (r_cnt >= WCNT'(AFT));
  assign cnt    = r_cnt;
  assign rddata = r_mem[r_rdptr];

  // During reset cnt is held at 0 by the async clear, so gating on rst is not
  // needed for the state update.
  assign w_wr_en = wrvld && w_not_full && !clr;
  assign w_rd_en = rdrdy && w_not_empty && !clr;

  always_comb begin
    w_wrptr_d = r_wrptr;
    w_rdptr_d = r_rdptr;
    w_cnt_d   = r_cnt;
    if (clr) begin
      w_wrptr_d = '0;
      w_rdptr_d = '0;
      w_cnt_d   = '0;
    end else begin
      // Explicit wrap at D-1 keeps non-power-of-two depths correct.
      if (w_wr_en) begin
        w_wrptr_d = (r_wrptr == WIDX'(D - 1)) ? '0 : r_wrptr + WIDX'(1);
      end
      if (w_rd_en) begin
        w_rdptr_d = (r_rdptr == WIDX'(D - 1)) ? '0 : r_rdptr + WIDX'(1);
      end
      if (w_wr_en && !w_rd_en) begin
        w_cnt_d = r_cnt + WCNT'(1);
      end else if (w_rd_en && !w_wr_en) begin
        w_cnt_d = r_cnt - WCNT'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrptr <= '0;
      r_rdptr <= '0;
      r_cnt   <= '0;
    end else begin
      r_wrptr <= w_wrptr_d;
      r_rdptr <= w_rdptr_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Storage is not reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wrptr] <= wrdata;
    end
  end

`ifdef POWLIB_SWFIFO_HWM_EN
  logic [WCNT-1:0] r_hwm;
  logic [WCNT-1:0] w_hwm_d;

  // Compare against next-cycle count so hwm tracks cnt in its peak cycle.
  always_comb begin
    w_hwm_d = r_hwm;
    if (clr) begin
      w_hwm_d = '0;
    end else if (w_cnt_d > r_hwm) begin
      w_hwm_d = w_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hwm <= '0;
    end else begin
      r_hwm <= w_hwm_d;
    end
  end

  assign hwm = r_hwm;
`endif

endmodule

// File: tb/tb_powlib_swfifo.sv
// Self-checking bench for powlib_swfifo (W=8, D=5, AFT=4). A queue-based
// reference model tracks expected contents, occupancy and high-water mark.
module tb_powlib_swfifo;

  localparam int unsigned W    = 8;
  localparam int unsigned D    = 5;
  localparam int unsigned AFT  = 4;
  localparam int unsigned WCNT = $clog2(D + 1);

  logic            clk;
  logic            rst;
  logic            clr;
  logic [W-1:0]    wrdata;
  logic            wrvld;
  logic            wrrdy;
  logic [W-1:0]    rddata;
  logic            rdvld;
  logic            rdrdy;
  logic [WCNT-1:0] cnt;
  logic            afull;
`ifdef POWLIB_SWFIFO_HWM_EN
  logic [WCNT-1:0] hwm;
`endif

  int n_tests;
  int n_fail;

  // Reference model state.
  logic [W-1:0] m_q[$];
  int           m_hwm;

  powlib_swfifo #(
    .W   (W),
    .D   (D),
    .AFT (AFT)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .wrdata (wrdata),
    .wrvld  (wrvld),
    .wrrdy  (wrrdy),
    .rddata (rddata),
    .rdvld  (rdvld),
    .rdrdy  (rdrdy),
    .cnt    (cnt),
    .afull  (afull)
`ifdef POWLIB_SWFIFO_HWM_EN
    ,
    .hwm    (hwm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic wv, input logic [W-1:0] wd, input logic rr, input logic cl);
    wrvld  = wv;
    wrdata = wd;
    rdrdy  = rr;
    clr    = cl;
  endtask

  // Applies the FIFO rules to the model for one clock edge.
  task automatic model_edge();
    bit wr_acc;
    bit rd_acc;
    if (!rst) return;
    if (clr) begin
      m_q.delete();
      m_hwm = 0;
      return;
    end
    wr_acc = wrvld && (m_q.size() < D);
    rd_acc = rdrdy && (m_q.size() > 0);
    if (rd_acc) void'(m_q.pop_front());
    if (wr_acc) m_q.push_back(wrdata);
    if (m_q.size() > m_hwm) m_hwm = m_q.size();
  endtask

  // One clock edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    m_q.delete();
    m_hwm = 0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (wrrdy !== 1'b0) begin n_fail++; $display("FAIL reset_wrrdy got %b want 0", wrrdy); end
    n_tests++; if (rdvld !== 1'b0) begin n_fail++; $display("FAIL reset_rdvld got %b want 0", rdvld); end
    n_tests++; if (afull !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %b want 0", afull); end
    n_tests++; if (cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (wrrdy !== 1'b1) begin n_fail++; $display("FAIL release_wrrdy got %b want 1", wrrdy); end
  endtask

  task automatic test_single();
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_tests++; if (rdvld !== 1'b1) begin n_fail++; $display("FAIL single_rdvld got %b want 1", rdvld); end
    n_tests++; if (rddata !== 8'h11) begin n_fail++; $display("FAIL single_rddata got %h want 11", rddata); end
    n_tests++; if (cnt !== WCNT'(1)) begin n_fail++; $display("FAIL single_cnt got %0d want 1", cnt); end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_tests++; if (rdvld !== 1'b0) begin n_fail++; $display("FAIL single_drain_rdvld got %b want 0", rdvld); end
    n_tests++; if (cnt !== '0) begin n_fail++; $display("FAIL single_drain_cnt got %0d want 0", cnt); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, W'(i), 1'b0, 1'b0);
      tick();
      n_tests++; if (cnt !== WCNT'(i)) begin n_fail++; $display("FAIL fill_cnt[%0d] got %0d want %0d", i, cnt, i); end
      n_tests++; if (afull !== (i >= 4)) begin n_fail++; $display("FAIL fill_afull[%0d] got %b want %b", i, afull, i >= 4); end
      n_tests++; if (wrrdy !== (i < 5)) begin n_fail++; $display("FAIL fill_wrrdy[%0d] got %b want %b", i, wrrdy, i < 5); end
    end
    // Sixth write held pending against a full FIFO.
    drive(1'b1, 8'h06, 1'b0, 1'b0);
    repeat (2) tick();
    n_tests++; if (cnt !== WCNT'(5)) begin n_fail++; $display("FAIL held_cnt got %0d want 5", cnt); end
    n_tests++; if (rddata !== 8'h01) begin n_fail++; $display("FAIL held_rddata got %h want 01", rddata); end
    n_tests++; if (wrrdy !== 1'b0) begin n_fail++; $display("FAIL held_wrrdy got %b want 0", wrrdy); end
  endtask

  task automatic test_full_rw();
    drive(1'b1, 8'h06, 1'b1, 1'b0);
    n_tests++; if (rddata !== 8'h01) begin n_fail++; $display("FAIL fullrw_head got %h want 01", rddata); end
    tick();
    n_tests++; if (cnt !== WCNT'(4)) begin n_fail++; $display("FAIL fullrw_cnt got %0d want 4", cnt); end
    n_tests++; if (wrrdy !== 1'b1) begin n_fail++; $display("FAIL fullrw_wrrdy got %b want 1", wrrdy); end
    n_tests++; if (rddata !== 8'h02) begin n_fail++; $display("FAIL fullrw_next got %h want 02", rddata); end
    drive(1'b1, 8'h06, 1'b0, 1'b0);
    tick();
    n_tests++; if (cnt !== WCNT'(5)) begin n_fail++; $display("FAIL fullrw_refill got %0d want 5", cnt); end
    // Expected remaining order: 02 03 04 05 06.
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (rddata !== W'(i + 2)) begin n_fail++; $display("FAIL fullrw_drain[%0d] got %h want %h", i, rddata, W'(i + 2)); end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_tests++; if (rdvld !== 1'b0) begin n_fail++; $display("FAIL fullrw_empty got %b want 0", rdvld); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 8'h1f, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, W'(8'h20 + i), 1'b1, 1'b0);
      n_tests++;
      if (rddata !== m_q[0]) begin n_fail++; $display("FAIL wrap_data[%0d] got %h want %h", i, rddata, m_q[0]); end
      tick();
      n_tests++;
      if (cnt !== WCNT'(1)) begin n_fail++; $display("FAIL wrap_cnt[%0d] got %0d want 1", i, cnt); end
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_tests++; if (rddata !== 8'h2b) begin n_fail++; $display("FAIL wrap_last got %h want 2b", rddata); end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_clr();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'(8'h40 + i), 1'b0, 1'b0);
      tick();
    end
    n_tests++; if (cnt !== WCNT'(3)) begin n_fail++; $display("FAIL clr_pre_cnt got %0d want 3", cnt); end
    drive(1'b1, 8'h99, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_tests++; if (cnt !== '0) begin n_fail++; $display("FAIL clr_cnt got %0d want 0", cnt); end
    n_tests++; if (rdvld !== 1'b0) begin n_fail++; $display("FAIL clr_rdvld got %b want 0", rdvld); end
    n_tests++; if (wrrdy !== 1'b1) begin n_fail++; $display("FAIL clr_wrrdy got %b want 1", wrrdy); end
`ifdef POWLIB_SWFIFO_HWM_EN
    n_tests++; if (hwm !== '0) begin n_fail++; $display("FAIL clr_hwm got %0d want 0", hwm); end
`endif
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_tests++; if (rddata !== 8'h77) begin n_fail++; $display("FAIL clr_after got %h want 77", rddata); end
    n_tests++; if (cnt !== WCNT'(1)) begin n_fail++; $display("FAIL clr_after_cnt got %0d want 1", cnt); end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, W'(8'h60 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_tests++; if (afull !== 1'b1) begin n_fail++; $display("FAIL arst_pre_afull got %b want 1", afull); end
    // Mid-cycle, away from any rising edge.
    #2 rst = 1'b0;
    m_q.delete();
    m_hwm = 0;
    #1;
    n_tests++; if (wrrdy !== 1'b0) begin n_fail++; $display("FAIL arst_wrrdy got %b want 0", wrrdy); end
    n_tests++; if (rdvld !== 1'b0) begin n_fail++; $display("FAIL arst_rdvld got %b want 0", rdvld); end
    n_tests++; if (afull !== 1'b0) begin n_fail++; $display("FAIL arst_afull got %b want 0", afull); end
    n_tests++; if (cnt !== '0) begin n_fail++; $display("FAIL arst_cnt got %0d want 0", cnt); end
`ifdef POWLIB_SWFIFO_HWM_EN
    n_tests++; if (hwm !== '0) begin n_fail++; $display("FAIL arst_hwm got %0d want 0", hwm); end
`endif
    #1 rst = 1'b1;
    drive(1'b1, 8'h5a, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_tests++; if (rddata !== 8'h5a) begin n_fail++; $display("FAIL arst_after got %h want 5a", rddata); end
    n_tests++; if (cnt !== WCNT'(1)) begin n_fail++; $display("FAIL arst_after_cnt got %0d want 1", cnt); end
  endtask

  task automatic test_random();
    int wr_pct;
    int rd_pct;
    int bad;
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      // Shift the write/read bias periodically to sweep full and empty.
      unique case ((c / 100) % 3)
        0:       begin wr_pct = 80; rd_pct = 30; end
        1:       begin wr_pct = 30; rd_pct = 80; end
        default: begin wr_pct = 60; rd_pct = 60; end
      endcase
      drive(($urandom_range(0, 99) < wr_pct), W'($urandom), ($urandom_range(0, 99) < rd_pct),
            ($urandom_range(0, 63) == 0));
      n_tests++;
      if (cnt !== WCNT'(m_q.size()) || rdvld !== (m_q.size() != 0) ||
          wrrdy !== (m_q.size() != D) || afull !== (m_q.size() >= AFT) ||
          (m_q.size() != 0 && rddata !== m_q[0])) begin
        n_fail++;
        if (bad < 10) begin
          $display("FAIL rand[%0d] got cnt=%0d vld=%b rdy=%b af=%b data=%h want cnt=%0d head=%h",
                   c, cnt, rdvld, wrrdy, afull, rddata, m_q.size(),
                   (m_q.size() != 0) ? m_q[0] : '0);
        end
        bad++;
      end
`ifdef POWLIB_SWFIFO_HWM_EN
      n_tests++;
      if (hwm !== WCNT'(m_hwm)) begin
        n_fail++;
        $display("FAIL rand_hwm[%0d] got %0d want %0d", c, hwm, m_hwm);
      end
`endif
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    test_reset();
    test_single();
    test_fill();
    test_full_rw();
    test_wrap();
    test_clr();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
